output_checker: RTL and testbench

Parametrised, clocked scoreboard that compares a behavioural (conditional) model against a structural model cycle by cycle. It sits in the testbench between the two models and the stimulus generator. It replaces the edge-triggered, display-only checker with a synchronous one that supports configurable data width, a model-latency offset, saturating error and check counters, first-mismatch capture and an error-limit halt. The block is testbench-side but written in synthesizable style; `$display` reporting is additional and never affects outputs.

---
 rtl/output_checker_pkg.sv | 17 +
 rtl/output_checker_delay_line.sv | 38 +++
 rtl/output_checker.sv | 146 ++++++++++++++
 tb/tb_output_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/output_checker_pkg.sv
// Shared definitions for the output_checker scoreboard: state encodings and
// default parameter values.
package output_checker_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_LATENCY   = 0;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_ERR_LIMIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/output_checker_delay_line.sv
// Enabled shift register that aligns the golden vector with the lagging model.
// DEPTH = 0 degenerates to a wire.
module check_delay_line #(
  parameter int W     = 5,
  parameter int DEPTH = 0
) (
  input  logic         CLK,
  input  logic         RESET_L,
  input  logic         EN,
  input  logic         CLR,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{CLK, RESET_L, EN, CLR};
      assign q = d;
    end else begin : g_sr
      logic [DEPTH-1:0][W-1:0] sr_q;

      always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
          sr_q <= '0;
        end else if (CLR) begin
          sr_q <= '0;
        end else if (EN) begin
          sr_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
      end

      assign q = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/output_checker.sv
// Cycle-by-cycle scoreboard comparing a golden (conditional) model against a
// structural model, with latency alignment, saturating counters and halt.
module output_checker
  import output_checker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic             CLEAR,
  input  logic [WIDTH-1:0] Qcond,
  input  logic             S_OUTcond,
  input  logic [WIDTH-1:0] Qstruct,
  input  logic             S_OUTstruct,
  output logic             ERR,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic [CNT_W-1:0] CHECK_COUNT,
  output logic [WIDTH:0]   FIRST_EXP,
  output logic [WIDTH:0]   FIRST_GOT,
  output logic             HALTED
);

  localparam int              GW      = WIDTH + 1;
  localparam logic [3:0]      LAT4    = 4'(LATENCY);
  localparam logic [31:0]     LIM     = 32'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [GW-1:0] g, g_dly, dv;
  assign g  = {S_OUTcond, Qcond};
  assign dv = {S_OUTstruct, Qstruct};

  check_delay_line #(.W(GW), .DEPTH(LATENCY)) u_dly (
    .CLK    (CLK),
    .RESET_L(RESET_L),
    .EN     (ENB),
    .CLR    (CLEAR),
    .d      (g),
    .q      (g_dly)
  );

  state_t           state_q, state_d;
  logic [3:0]       ecnt_q, ecnt_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [GW-1:0]    fexp_q, fexp_d;
  logic [GW-1:0]    fgot_q, fgot_d;

  logic             mis, do_cmp;
  logic [CNT_W-1:0] err_nx;

  // Case inequality so an X/Z on the model under test counts as a mismatch.
  assign mis    = (g_dly !== dv);
  // ecnt_q counts prior enabled edges since IDLE; the edge where it reaches
  // LATENCY is the first compare, even before the state register says CHECK.
  assign do_cmp = ENB && !CLEAR &&
                  ((state_q == ST_CHECK) ||
                   ((state_q == ST_IDLE || state_q == ST_FILL) && ecnt_q == LAT4));
  assign err_nx = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    ecnt_d    = ecnt_q;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    err_cnt_d = err_cnt_q;
    chk_cnt_d = chk_cnt_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    if (CLEAR) begin
      sticky_d  = 1'b0;
      err_cnt_d = '0;
      chk_cnt_d = '0;
      fexp_d    = '0;
      fgot_d    = '0;
      ecnt_d    = '0;
      if (!ENB)              state_d = ST_IDLE;
      else if (LAT4 == 4'd0) state_d = ST_CHECK;
      else                   state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_HALT: ;
        default: begin
          if (!ENB) begin
            state_d = ST_IDLE;
            ecnt_d  = '0;
          end else if (do_cmp) begin
            state_d = ST_CHECK;
            if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + CNT_ONE;
            if (mis) begin
              err_d     = 1'b1;
              err_cnt_d = err_nx;
              if (!sticky_q) begin
                sticky_d = 1'b1;
                fexp_d   = g_dly;
                fgot_d   = dv;
              end
              if (ERR_LIMIT != 0 && 32'(err_nx) == LIM) state_d = ST_HALT;
            end
          end else begin
            state_d = ST_FILL;
            ecnt_d  = ecnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= ST_IDLE;
      ecnt_q    <= '0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
    end else begin
      state_q   <= state_d;
      ecnt_q    <= ecnt_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
    end
  end

  assign ERR         = err_q;
  assign ERR_STICKY  = sticky_q;
  assign ERR_COUNT   = err_cnt_q;
  assign CHECK_COUNT = chk_cnt_q;
  assign FIRST_EXP   = fexp_q;
  assign FIRST_GOT   = fgot_q;
  assign HALTED      = (state_q == ST_HALT);

endmodule

// File: tb/tb_output_checker.sv
// Directed bench for output_checker: four instances (default, LATENCY=2,
// ERR_LIMIT=3, CNT_W=3) sharing data buses, each with its own enable/clear.
module tb_output_checker;
  import output_checker_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic [3:0] qc, qs;
  logic       sc, ss;
  logic [3:0] enb, clr;

  logic [3:0] err_o, sticky_o, halt_o;
  logic [7:0] errc [3];
  logic [7:0] chkc [3];
  logic [2:0] errc3, chkc3;
  logic [4:0] fexp [4];
  logic [4:0] fgot [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  output_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(8), .ERR_LIMIT(0)) u0 (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(enb[0]), .CLEAR(clr[0]),
    .Qcond(qc), .S_OUTcond(sc), .Qstruct(qs), .S_OUTstruct(ss),
    .ERR(err_o[0]), .ERR_STICKY(sticky_o[0]), .ERR_COUNT(errc[0]),
    .CHECK_COUNT(chkc[0]), .FIRST_EXP(fexp[0]), .FIRST_GOT(fgot[0]),
    .HALTED(halt_o[0]));

  output_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(8), .ERR_LIMIT(0)) u1 (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(enb[1]), .CLEAR(clr[1]),
    .Qcond(qc), .S_OUTcond(sc), .Qstruct(qs), .S_OUTstruct(ss),
    .ERR(err_o[1]), .ERR_STICKY(sticky_o[1]), .ERR_COUNT(errc[1]),
    .CHECK_COUNT(chkc[1]), .FIRST_EXP(fexp[1]), .FIRST_GOT(fgot[1]),
    .HALTED(halt_o[1]));

  output_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(8), .ERR_LIMIT(3)) u2 (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(enb[2]), .CLEAR(clr[2]),
    .Qcond(qc), .S_OUTcond(sc), .Qstruct(qs), .S_OUTstruct(ss),
    .ERR(err_o[2]), .ERR_STICKY(sticky_o[2]), .ERR_COUNT(errc[2]),
    .CHECK_COUNT(chkc[2]), .FIRST_EXP(fexp[2]), .FIRST_GOT(fgot[2]),
    .HALTED(halt_o[2]));

  output_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(3), .ERR_LIMIT(0)) u3 (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(enb[3]), .CLEAR(clr[3]),
    .Qcond(qc), .S_OUTcond(sc), .Qstruct(qs), .S_OUTstruct(ss),
    .ERR(err_o[3]), .ERR_STICKY(sticky_o[3]), .ERR_COUNT(errc3),
    .CHECK_COUNT(chkc3), .FIRST_EXP(fexp[3]), .FIRST_GOT(fgot[3]),
    .HALTED(halt_o[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET_L = 1'b0;
    qc = '0; qs = '0; sc = 1'b0; ss = 1'b0;
    enb = '0; clr = '0;
    step(); step();

    // reset values
    chk("rst err",    32'(err_o),    32'h0);
    chk("rst sticky", 32'(sticky_o), 32'h0);
    chk("rst halt",   32'(halt_o),   32'h0);
    chk("rst errc0",  32'(errc[0]),  32'h0);
    chk("rst chkc0",  32'(chkc[0]),  32'h0);
    chk("rst fexp0",  32'(fexp[0]),  32'h0);
    chk("rst fgot0",  32'(fgot[0]),  32'h0);
    RESET_L = 1'b1;
    step();

    // matching ramp, LATENCY 0
    enb[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      qc = i[3:0]; qs = i[3:0]; sc = i[0]; ss = i[0];
      step();
      chk("ramp err", 32'(err_o[0]), 32'h0);
    end
    chk("ramp chkc", 32'(chkc[0]), 32'd16);
    chk("ramp errc", 32'(errc[0]), 32'd0);
    enb[0] = 1'b0;
    step();
    chk("idle hold chkc", 32'(chkc[0]), 32'd16);

    // single fault at cycle 10
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    chk("clr chkc0", 32'(chkc[0]), 32'd0);
    enb[0] = 1'b1; sc = 1'b0; ss = 1'b0;
    for (int i = 0; i < 16; i++) begin
      qc = (i == 10) ? 4'h7 : i[3:0];
      qs = (i == 10) ? 4'h5 : i[3:0];
      step();
      chk("fault err", 32'(err_o[0]), (i == 10) ? 32'h1 : 32'h0);
    end
    enb[0] = 1'b0;
    chk("fault errc",   32'(errc[0]),     32'd1);
    chk("fault chkc",   32'(chkc[0]),     32'd16);
    chk("fault fexp",   32'(fexp[0]),     32'h07);
    chk("fault fgot",   32'(fgot[0]),     32'h05);
    chk("fault sticky", 32'(sticky_o[0]), 32'h1);

    // LATENCY 2, aligned
    enb[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      qc = i[3:0];
      qs = (i >= 2) ? 4'(i - 2) : 4'h0;
      step();
      chk("lat2 chkc", 32'(chkc[1]), (i >= 2) ? 32'(i - 1) : 32'h0);
      chk("lat2 err",  32'(err_o[1]), 32'h0);
    end
    chk("lat2 errc", 32'(errc[1]), 32'd0);
    enb[1] = 1'b0;
    clr[1] = 1'b1; step(); clr[1] = 1'b0;

    // LATENCY 2, struct lags by only one cycle
    enb[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      qc = i[3:0];
      qs = (i >= 1) ? 4'(i - 1) : 4'h0;
      step();
      chk("lat1 err", 32'(err_o[1]), (i >= 2) ? 32'h1 : 32'h0);
    end
    enb[1] = 1'b0;
    chk("lat1 errc", 32'(errc[1]), 32'd10);
    chk("lat1 chkc", 32'(chkc[1]), 32'd10);
    chk("lat1 fexp", 32'(fexp[1]), 32'h00);
    chk("lat1 fgot", 32'(fgot[1]), 32'h01);

    // error limit 3
    qc = 4'h0; qs = 4'h1; sc = 1'b0; ss = 1'b0;
    enb[2] = 1'b1;
    step();
    chk("lim e1 err",  32'(err_o[2]),  32'h1);
    chk("lim e1 errc", 32'(errc[2]),   32'd1);
    chk("lim e1 halt", 32'(halt_o[2]), 32'h0);
    step();
    chk("lim e2 errc", 32'(errc[2]),   32'd2);
    step();
    chk("lim e3 err",  32'(err_o[2]),  32'h1);
    chk("lim e3 errc", 32'(errc[2]),   32'd3);
    chk("lim e3 halt", 32'(halt_o[2]), 32'h1);
    step(); step();
    chk("halt err",  32'(err_o[2]),  32'h0);
    chk("halt errc", 32'(errc[2]),   32'd3);
    chk("halt chkc", 32'(chkc[2]),   32'd3);
    chk("halt halt", 32'(halt_o[2]), 32'h1);
    enb[2] = 1'b0;
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    chk("hclr errc",   32'(errc[2]),     32'd0);
    chk("hclr chkc",   32'(chkc[2]),     32'd0);
    chk("hclr sticky", 32'(sticky_o[2]), 32'h0);
    chk("hclr halt",   32'(halt_o[2]),   32'h0);
    chk("hclr fexp",   32'(fexp[2]),     32'h0);
    chk("hclr fgot",   32'(fgot[2]),     32'h0);

    // saturation, CNT_W 3
    enb[3] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    enb[3] = 1'b0;
    chk("sat errc", 32'(errc3), 32'd7);
    chk("sat chkc", 32'(chkc3), 32'd7);

    // async reset mid-CHECK
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    enb[0] = 1'b1; qc = 4'h2; qs = 4'h3;
    step(); step();
    chk("pre-rst errc", 32'(errc[0]), 32'd2);
    #3 RESET_L = 1'b0;
    #1;
    chk("arst errc",   32'(errc[0]),        32'd0);
    chk("arst chkc",   32'(chkc[0]),        32'd0);
    chk("arst err",    32'(err_o[0]),       32'h0);
    chk("arst sticky", 32'(sticky_o[0]),    32'h0);
    chk("arst fexp",   32'(fexp[0]),        32'h0);
    chk("arst fgot",   32'(fgot[0]),        32'h0);
    chk("arst halt",   32'(halt_o[0]),      32'h0);
    chk("arst state",  32'(u0.state_q),     32'(ST_IDLE));
    step();
    RESET_L = 1'b1;

    // X on serial output under test
    qc = 4'h3; qs = 4'h3; sc = 1'b1; ss = 1'bx;
    step();
    chk("x err",  32'(err_o[0]), 32'h1);
    chk("x errc", 32'(errc[0]),  32'd1);
    enb[0] = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
